// File: rtl/id_stage_if.sv
// IF/ID, ID/EX, register-file read and writeback signals of the decode stage.
// Both handshakes are valid/ready: a beat moves on a rising edge where give and get are both high.
interface id_stage_if #(
  parameter int BITSIZE = 32
);
  logic               flush_i;
  logic               IF_ID_give_i;
  logic               ID_IF_get_o;
  logic [31:0]        IF_ID_instr_i;
  logic [BITSIZE-1:0] IF_ID_pc_i;
  logic               ID_EX_give_o;
  logic               EX_ID_get_i;
  logic [31:0]        ID_EX_instruction_o;
  logic [BITSIZE-1:0] ID_EX_pc_o;
  logic [BITSIZE-1:0] ID_EX_rs1_o;
  logic [BITSIZE-1:0] ID_EX_rs2_o;
  logic [BITSIZE-1:0] ID_EX_imm_o;
  logic [4:0]         ID_REG_rs1_o;
  logic [4:0]         ID_REG_rs2_o;
  logic [BITSIZE-1:0] REG_ID_rs1_d_i;
  logic [BITSIZE-1:0] REG_ID_rs2_d_i;
  logic               WB_ID_clr_i;
  logic [4:0]         WB_ID_rd_i;
  logic               inv_instr_o;

  modport slave (
    input  flush_i, IF_ID_give_i, IF_ID_instr_i, IF_ID_pc_i, EX_ID_get_i,
           REG_ID_rs1_d_i, REG_ID_rs2_d_i, WB_ID_clr_i, WB_ID_rd_i,
    output ID_IF_get_o, ID_EX_give_o, ID_EX_instruction_o, ID_EX_pc_o,
           ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_imm_o, ID_REG_rs1_o, ID_REG_rs2_o,
           inv_instr_o
  );

  modport master (
    output flush_i, IF_ID_give_i, IF_ID_instr_i, IF_ID_pc_i, EX_ID_get_i,
           REG_ID_rs1_d_i, REG_ID_rs2_d_i, WB_ID_clr_i, WB_ID_rd_i,
    input  ID_IF_get_o, ID_EX_give_o, ID_EX_instruction_o, ID_EX_pc_o,
           ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_imm_o, ID_REG_rs1_o, ID_REG_rs2_o,
           inv_instr_o
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: one-entry holding register, immediate generation, and a
// per-register scoreboard that stalls issue on read-after-write hazards.
module id_stage #(
  parameter int BITSIZE       = 32,
  parameter bit SCOREBOARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn_i,
  id_stage_if.slave   bus,
  output logic        dbg_state_o,
  output logic [31:0] dbg_sb_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [BITSIZE-1:0] pc_q, pc_d;
  logic [31:0]        sb_q, sb_d;

  logic [6:0]         opcode;
  logic [4:0]         rs1_idx, rs2_idx, rd_idx;
  logic               op_valid, rs1_used, rs2_used, rd_written;
  logic [31:0]        imm32;
  logic [BITSIZE-1:0] imm_ext;
  logic               hazard;
  logic               full, give, ex_xfer, inv_drop, get, if_xfer;

  // Decode of the held instruction only; IF inputs never reach the outputs directly.
  always_comb begin
    opcode     = instr_q[6:0];
    rs1_idx    = instr_q[19:15];
    rs2_idx    = instr_q[24:20];
    rd_idx     = instr_q[11:7];
    op_valid   = 1'b0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    rd_written = 1'b0;
    imm32      = 32'd0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        op_valid   = 1'b1;
        rd_written = 1'b1;
        imm32      = {instr_q[31:12], 12'd0};
      end
      OP_JAL: begin
        op_valid   = 1'b1;
        rd_written = 1'b1;
        imm32      = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                      instr_q[20], instr_q[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        op_valid   = 1'b1;
        rs1_used   = 1'b1;
        rd_written = 1'b1;
        imm32      = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      OP_BRANCH: begin
        op_valid = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32    = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
      end
      OP_STORE: begin
        op_valid = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      OP_OP: begin
        op_valid   = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        rd_written = 1'b1;
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
    imm_ext       = {BITSIZE{imm32[31]}};
    imm_ext[31:0] = imm32;
  end

  // A writeback clear lands in sb_q one edge later, so it never unblocks the same cycle.
  always_comb begin
    full   = (state_q == FULL);
    hazard = full && ((rs1_used && (rs1_idx != 5'd0) && sb_q[rs1_idx]) ||
                      (rs2_used && (rs2_idx != 5'd0) && sb_q[rs2_idx]));
  end

  // FSM output / handshake logic.
  always_comb begin
    give     = full && op_valid && !hazard && !bus.flush_i;
    ex_xfer  = give && bus.EX_ID_get_i;
    inv_drop = full && !op_valid && !bus.flush_i;
    get      = !bus.flush_i && (!full || ex_xfer || inv_drop);
    if_xfer  = get && bus.IF_ID_give_i;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (if_xfer) state_d = FULL;
      end
      FULL: begin
        if (bus.flush_i)             state_d = EMPTY;
        else if (ex_xfer || inv_drop) state_d = if_xfer ? FULL : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (if_xfer) begin
      instr_d = bus.IF_ID_instr_i;
      pc_d    = bus.IF_ID_pc_i;
    end
  end

  // Set is applied after clear so a same-index set/clear leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (bus.WB_ID_clr_i) sb_d[bus.WB_ID_rd_i] = 1'b0;
    if (ex_xfer && rd_written && (rd_idx != 5'd0)) sb_d[rd_idx] = 1'b1;
    if (!SCOREBOARD_EN) sb_d = 32'd0;
  end

  // FSM state register plus holding and scoreboard registers.
  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_q <= EMPTY;
      instr_q <= 32'd0;
      pc_q    <= '0;
      sb_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      sb_q    <= sb_d;
    end
  end

  // While reset is asserted every output is forced quiet, even if a beat is held.
  always_comb begin
    bus.ID_IF_get_o         = resetn_i && get;
    bus.ID_EX_give_o        = resetn_i && give;
    bus.inv_instr_o         = resetn_i && inv_drop;
    bus.ID_EX_instruction_o = resetn_i ? instr_q : 32'd0;
    bus.ID_EX_pc_o          = resetn_i ? pc_q : '0;
    bus.ID_EX_imm_o         = resetn_i ? imm_ext : '0;
    bus.ID_REG_rs1_o        = (resetn_i && rs1_used) ? rs1_idx : 5'd0;
    bus.ID_REG_rs2_o        = (resetn_i && rs2_used) ? rs2_idx : 5'd0;
    bus.ID_EX_rs1_o         = (resetn_i && rs1_used) ? bus.REG_ID_rs1_d_i : '0;
    bus.ID_EX_rs2_o         = (resetn_i && rs2_used) ? bus.REG_ID_rs2_d_i : '0;
    dbg_state_o             = state_q;
    dbg_sb_o                = sb_q;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: issued beats are checked in order against an
// expected queue filled by the drivers with hand-computed values.
module tb_id_stage;
  localparam int BITSIZE = 32;
  localparam int W       = 160;

  logic        clk = 1'b0;
  logic        resetn_i = 1'b0;
  logic        dbg_state;
  logic [31:0] dbg_sb;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_give_cyc = 0;
  int          prev_give_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  id_stage_if #(.BITSIZE(BITSIZE)) bus ();

  id_stage #(.BITSIZE(BITSIZE), .SCOREBOARD_EN(1'b1)) dut (
    .clk         (clk),
    .resetn_i    (resetn_i),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_sb_o    (dbg_sb)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rfv(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : (32'hA000_0000 | {27'd0, idx});
  endfunction

  assign bus.REG_ID_rs1_d_i = rfv(bus.ID_REG_rs1_o);
  assign bus.REG_ID_rs2_d_i = rfv(bus.ID_REG_rs2_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.IF_ID_give_i  = 1'b1;
    bus.IF_ID_instr_i = instr;
    bus.IF_ID_pc_i    = pc;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic [31:0] rs2);
    exp_q.push_back({instr, pc, imm, rs1, rs2});
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] rs1,
                      input logic [31:0] rs2, input bit issues);
    bit got = 1'b0;
    present(instr, pc);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.ID_IF_get_o) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: instr %08h not accepted, required within 50 cycles", instr);
    end else if (issues) begin
      push_exp(instr, pc, imm, rs1, rs2);
    end
    to_pos();
  endtask

  task automatic idle_if();
    bus.IF_ID_give_i = 1'b0;
  endtask

  task automatic wb_clear(input logic [4:0] rd);
    bus.WB_ID_clr_i = 1'b1;
    bus.WB_ID_rd_i  = rd;
    to_pos();
    bus.WB_ID_clr_i = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn_i && bus.ID_EX_give_o && bus.EX_ID_get_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got instr %08h, required no issue", bus.ID_EX_instruction_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_instr", bus.ID_EX_instruction_o, mon_e[159:128]);
        check("issue_pc",    bus.ID_EX_pc_o,          mon_e[127:96]);
        check("issue_imm",   bus.ID_EX_imm_o,         mon_e[95:64]);
        check("issue_rs1",   bus.ID_EX_rs1_o,         mon_e[63:32]);
        check("issue_rs2",   bus.ID_EX_rs2_o,         mon_e[31:0]);
      end
      prev_give_cyc = last_give_cyc;
      last_give_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush_i       = 1'b0;
    bus.IF_ID_give_i  = 1'b0;
    bus.IF_ID_instr_i = 32'd0;
    bus.IF_ID_pc_i    = 32'd0;
    bus.EX_ID_get_i   = 1'b1;
    bus.WB_ID_clr_i   = 1'b0;
    bus.WB_ID_rd_i    = 5'd0;

    // reset state
    repeat (2) @(posedge clk);
    to_neg();
    check("rst_get",   bus.ID_IF_get_o, 0);
    check("rst_give",  bus.ID_EX_give_o, 0);
    check("rst_inv",   bus.inv_instr_o, 0);
    check("rst_state", dbg_state, 0);
    check("rst_sb",    dbg_sb, 0);
    check("rst_pc_o",  bus.ID_EX_pc_o, 0);
    to_pos();
    resetn_i = 1'b1;
    to_neg();
    check("empty_get",  bus.ID_IF_get_o, 1);
    check("empty_give", bus.ID_EX_give_o, 0);
    to_pos();

    // back-to-back ADDI x1,x0,5 ; ADD x2,x3,x4
    send(32'h0050_0093, 32'h100, 32'd5, 32'd0, 32'd0, 1);
    send(32'h0041_8133, 32'h104, 32'd0, rfv(3), rfv(4), 1);
    idle_if();
    to_neg();
    to_pos();
    to_neg();
    check("b2b_gap", last_give_cyc - prev_give_cyc, 1);
    check("b2b_sb",  dbg_sb, 32'h0000_0006);
    to_pos();
    wb_clear(5'd1);
    wb_clear(5'd2);
    to_neg();
    check("wb_clear_sb", dbg_sb, 32'h0);
    to_pos();

    // RAW: ADDI x1,x0,1 ; ADD x5,x1,x1
    send(32'h0010_0093, 32'h200, 32'd1, 32'd0, 32'd0, 1);
    send(32'h0010_82B3, 32'h204, 32'd0, rfv(1), rfv(1), 1);
    idle_if();
    to_neg();
    check("raw_sb_set", dbg_sb, 32'h0000_0002);
    check("raw_stall0", bus.ID_EX_give_o, 0);
    to_pos();
    for (int i = 0; i < 2; i++) begin
      to_neg();
      check("raw_stall", bus.ID_EX_give_o, 0);
      to_pos();
    end
    bus.WB_ID_clr_i = 1'b1;
    bus.WB_ID_rd_i  = 5'd1;
    to_neg();
    check("raw_clr_cycle", bus.ID_EX_give_o, 0);
    to_pos();
    bus.WB_ID_clr_i = 1'b0;
    to_neg();
    check("raw_release", bus.ID_EX_give_o, 1);
    to_pos();
    to_neg();
    check("raw_sb", dbg_sb, 32'h0000_0020);
    to_pos();

    // immediates: BEQ -4, JAL x0 -2048, LUI x7 0xABCDE, SW x2,-8(x3)
    send(32'hFE00_0EE3, 32'h300, 32'hFFFF_FFFC, 32'd0, 32'd0, 1);
    send(32'h801F_F06F, 32'h304, 32'hFFFF_F800, 32'd0, 32'd0, 1);
    send(32'hABCD_E3B7, 32'h308, 32'hABCD_E000, 32'd0, 32'd0, 1);
    send(32'hFE21_AC23, 32'h30C, 32'hFFFF_FFF8, rfv(3), rfv(2), 1);
    idle_if();
    to_neg();
    to_pos();
    to_neg();
    check("imm_sb", dbg_sb, 32'h0000_00A0);
    to_pos();

    // invalid opcode followed by ADDI x1,x0,5
    send(32'h0000_007F, 32'h400, 32'd0, 32'd0, 32'd0, 0);
    present(32'h0050_0093, 32'h404);
    to_neg();
    check("inv_pulse",   bus.inv_instr_o, 1);
    check("inv_no_give", bus.ID_EX_give_o, 0);
    check("inv_get",     bus.ID_IF_get_o, 1);
    push_exp(32'h0050_0093, 32'h404, 32'd5, 32'd0, 32'd0);
    to_pos();
    idle_if();
    to_neg();
    check("inv_one_cycle", bus.inv_instr_o, 0);
    to_pos();
    to_neg();
    check("inv_sb", dbg_sb, 32'h0000_00A2);
    to_pos();

    // backpressure, then set+clear of x2 in the same cycle
    bus.EX_ID_get_i = 1'b0;
    send(32'h0041_8133, 32'h500, 32'd0, rfv(3), rfv(4), 1);
    present(32'h1234_5437, 32'h504);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("bp_give",  bus.ID_EX_give_o, 1);
      check("bp_get",   bus.ID_IF_get_o, 0);
      check("bp_instr", bus.ID_EX_instruction_o, 32'h0041_8133);
      check("bp_pc",    bus.ID_EX_pc_o, 32'h500);
      to_pos();
    end
    bus.EX_ID_get_i = 1'b1;
    bus.WB_ID_clr_i = 1'b1;
    bus.WB_ID_rd_i  = 5'd2;
    to_neg();
    check("bp_release_get", bus.ID_IF_get_o, 1);
    push_exp(32'h1234_5437, 32'h504, 32'h1234_5000, 32'd0, 32'd0);
    to_pos();
    bus.WB_ID_clr_i = 1'b0;
    idle_if();
    to_neg();
    check("set_wins_sb", dbg_sb, 32'h0000_00A6);
    to_pos();
    to_neg();
    check("bp_sb", dbg_sb, 32'h0000_01A6);
    to_pos();

    // flush while FULL
    bus.EX_ID_get_i = 1'b0;
    send(32'h0070_0513, 32'h600, 32'd7, 32'd0, 32'd0, 0);
    present(32'h0030_0493, 32'h604);
    bus.flush_i = 1'b1;
    to_neg();
    check("fl_give", bus.ID_EX_give_o, 0);
    check("fl_get",  bus.ID_IF_get_o, 0);
    to_pos();
    bus.flush_i = 1'b0;
    idle_if();
    to_neg();
    check("fl_state",      dbg_state, 0);
    check("fl_give_after", bus.ID_EX_give_o, 0);
    check("fl_sb_kept",    dbg_sb, 32'h0000_01A6);
    to_pos();

    // reset while FULL
    send(32'h0030_0493, 32'h700, 32'd3, 32'd0, 32'd0, 0);
    resetn_i = 1'b0;
    present(32'h0070_0513, 32'h704);
    to_neg();
    check("rs_give",  bus.ID_EX_give_o, 0);
    check("rs_get",   bus.ID_IF_get_o, 0);
    check("rs_inv",   bus.inv_instr_o, 0);
    check("rs_instr", bus.ID_EX_instruction_o, 0);
    to_pos();
    resetn_i = 1'b1;
    idle_if();
    bus.EX_ID_get_i = 1'b1;
    to_neg();
    check("rs_state", dbg_state, 0);
    check("rs_give_after", bus.ID_EX_give_o, 0);
    check("rs_sb", dbg_sb, 32'h0);
    to_pos();

    // operation after reset
    send(32'h0050_0093, 32'h800, 32'd5, 32'd0, 32'd0, 1);
    idle_if();
    to_neg();
    to_pos();
    to_neg();
    check("final_sb", dbg_sb, 32'h0000_0002);
    check("exp_q_drained", exp_q.size(), 0);
    to_pos();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter BITSIZE, default 32, datapath width of operands, immediate and PC; SHALL be >= 32.
REQ-002 Parameter SCOREBOARD_EN, default 1, enables the RAW hazard interlock (0: interlock disabled, scoreboard held at zero).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-004 resetn_i  in  1  reset, synchronous, active-low.
REQ-005 flush_i  in  1  discard held instruction.
REQ-006 IF_ID_give_i  in  1 / ID_IF_get_o  out  1  IF->ID handshake; transfer when both high.
REQ-007 IF_ID_instr_i  in  32 / IF_ID_pc_i  in  BITSIZE  instruction and its PC.
REQ-008 ID_EX_give_o  out  1 / EX_ID_get_i  in  1  ID->EX handshake; transfer when both high.
REQ-009 ID_EX_instruction_o  out  32; ID_EX_pc_o, ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_imm_o  out  BITSIZE each.
REQ-010 ID_REG_rs1_o, ID_REG_rs2_o  out  5; REG_ID_rs1_d_i, REG_ID_rs2_d_i  in  BITSIZE  register-file read port.
REQ-011 WB_ID_clr_i  in  1 / WB_ID_rd_i  in  5  writeback completion, clears scoreboard bit.
REQ-012 inv_instr_o  out  1  invalid-opcode pulse.

Function
REQ-013 FSM states EMPTY, FULL; EMPTY->FULL on IF transfer; FULL->EMPTY on EX transfer without simultaneous IF transfer, on invalid drop, or on flush_i; FULL->FULL on EX transfer with simultaneous IF transfer.
REQ-014 ID_IF_get_o = !flush_i && (EMPTY || EX transfer this cycle || invalid drop this cycle); throughput one instruction per cycle, zero bubbles.
REQ-015 Accepted instruction and PC SHALL be captured into internal registers; all outputs derive from these registers, never directly from IF_ID_* inputs.
REQ-016 Valid opcodes[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; all others invalid.
REQ-017 Immediate per format (I, S, B, U, J), sign-extended from instr[31] to BITSIZE; B/J bit0 = 0; U lower 12 bits = 0; OP imm = 0.
REQ-018 rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 used by BRANCH, STORE, OP; unused ID_REG_rsX_o and ID_EX_rsX_o SHALL be 0.
REQ-019 rd written by all valid opcodes except BRANCH, STORE; rd = 0 never marks the scoreboard.
REQ-020 ID_REG_rsX_o combinational from held instruction; ID_EX_rsX_o = REG_ID_rsX_d_i when used.
REQ-021 Hazard = FULL && ((rs1 used && rs1!=0 && sb[rs1]) || (rs2 used && rs2!=0 && sb[rs2])).
REQ-022 ID_EX_give_o = FULL && valid opcode && !hazard && !flush_i.
REQ-023 On EX transfer with rd written and rd!=0, sb[rd] SHALL be set next cycle.
REQ-024 WB_ID_clr_i clears sb[WB_ID_rd_i] next cycle; same-cycle set and clear of same index: set wins.
REQ-025 Clear takes effect the following cycle; no bypass of a same-cycle clear into hazard.
REQ-026 Invalid opcode in FULL: inv_instr_o high exactly one cycle, instruction dropped, no EX transfer, scoreboard unchanged.
REQ-027 flush_i: state -> EMPTY, held instruction discarded, scoreboard unchanged, no transfer either side that cycle.
REQ-028 ID_EX_instruction_o, ID_EX_pc_o, ID_EX_imm_o hold held-register values; meaningful only while ID_EX_give_o high.

Reset
REQ-029 resetn_i low at a clock edge: state EMPTY, instruction/PC registers 0, scoreboard all 0, regardless of in-flight handshakes.
REQ-030 During reset all handshake outputs and inv_instr_o SHALL be 0; data outputs 0.

Verification
REQ-031 Back-to-back: ADDI x1,x0,5 then ADD x2,x3,x4, EX_ID_get_i=1 -> two gives on consecutive cycles, imm 5 then 0, sb[1],sb[2] set.
REQ-032 RAW: ADDI x1,x0,1 issued, then ADD x5,x1,x1 -> give low until WB_ID_clr_i with rd=1, give high the cycle after clear.
REQ-033 Immediates: BEQ offset -4, JAL offset -2048, LUI 0xABCDE -> imm 0xFFFFFFFC, 0xFFFFF800, 0xABCDE000.
REQ-034 Invalid 0x0000007F -> inv_instr_o one-cycle pulse, no give, next instruction accepted same cycle.
REQ-035 Backpressure: EX_ID_get_i=0 for 3 cycles -> give held high, outputs stable, ID_IF_get_o low; set+clear same rd same cycle -> bit remains set.
REQ-036 flush_i and resetn_i asserted while FULL -> EMPTY next cycle, no give; reset additionally zeroes scoreboard, flush preserves it.
